// File: rtl/tpu_sram_pkg.sv
// Shared types and the byte-lane merge helper for the multi-port scratchpad bank.
package tpu_sram_pkg;

   typedef enum logic {S_CLEAR, S_READY} sram_state_t;

   // Widest word the merge helper handles; callers zero-extend and truncate.
   localparam int MAX_DW = 256;

   function automatic logic [MAX_DW-1:0] lane_merge(
      input logic [MAX_DW-1:0] old_w,
      input logic [MAX_DW-1:0] new_w,
      input logic [MAX_DW-1:0] be,
      input int                lane_w
   );
      logic [MAX_DW-1:0] m;
      for (int b = 0; b < MAX_DW; b++)
         m[b] = be[b / lane_w] ? new_w[b] : old_w[b];
      return m;
   endfunction

endpackage

// File: rtl/sram_rd_port.sv
// One registered read port: range check, write-first bypass and output registers.
module sram_rd_port
   import tpu_sram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_ELEM   = 8,
   parameter int LANE_W     = 8,
   parameter int AW         = 3,
   localparam int NUM_LANES = DATA_WIDTH / LANE_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  acc,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   input  logic [DATA_WIDTH-1:0] mem_word,
   input  logic                  wr_en,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [NUM_LANES-1:0]  wbe,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid
);

   localparam logic [AW:0] ELEM_CNT = (AW+1)'(NUM_ELEM);

   logic [DATA_WIDTH-1:0] rd_word;

   // Same-cycle write to the same word is visible to the read (write-first).
   always_comb begin
      rd_word = mem_word;
      if ({1'b0, raddr} >= ELEM_CNT)
         rd_word = '0;
      else if (wr_en && (waddr == raddr))
         rd_word = DATA_WIDTH'(lane_merge(MAX_DW'(mem_word), MAX_DW'(wdata),
                                          MAX_DW'(wbe), LANE_W));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= acc & re;
         if (acc && re)
            rdata <= rd_word;
      end
   end

endmodule

// File: rtl/sram_bank_mp.sv
// Scratchpad bank: one byte-enabled write port, NUM_RD registered read ports,
// contents cleared by a one-word-per-cycle sweep after reset and on request.
module sram_bank_mp
   import tpu_sram_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    NUM_ELEM   = 8,
   parameter int                    NUM_RD     = 2,
   parameter int                    LANE_W     = 8,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0,
   localparam int                   AW         = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1,
   localparam int                   NUM_LANES  = DATA_WIDTH / LANE_W
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               clear,
   output logic                               ready,
   input  logic                               we,
   input  logic [AW-1:0]                      waddr,
   input  logic [DATA_WIDTH-1:0]              wdata,
   input  logic [NUM_LANES-1:0]               wbe,
   input  logic [NUM_RD-1:0]                  re,
   input  logic [NUM_RD-1:0][AW-1:0]          raddr,
   output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  rdata,
   output logic [NUM_RD-1:0]                  rvalid
);

   localparam logic [AW:0]   ELEM_CNT = (AW+1)'(NUM_ELEM);
   localparam logic [AW-1:0] LAST     = AW'(NUM_ELEM - 1);

   logic [DATA_WIDTH-1:0] mem [NUM_ELEM];

   sram_state_t           state, state_nxt;
   logic [AW-1:0]         clr_ptr, ptr_nxt;
   logic                  acc, sweep, wr_en;
   logic [DATA_WIDTH-1:0] wr_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_CLEAR;
         clr_ptr <= '0;
      end else begin
         state   <= state_nxt;
         clr_ptr <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = clr_ptr;
      case (state)
         S_CLEAR: begin
            if (clear)
               ptr_nxt = '0;
            else if (clr_ptr == LAST) begin
               state_nxt = S_READY;
               ptr_nxt   = '0;
            end else
               ptr_nxt = clr_ptr + 1'b1;
         end
         S_READY: begin
            if (clear) begin
               state_nxt = S_CLEAR;
               ptr_nxt   = '0;
            end
         end
         default: state_nxt = S_CLEAR;
      endcase
   end

   // A clear request drops any write or read presented in the same cycle.
   always_comb begin
      ready = (state == S_READY);
      sweep = (state == S_CLEAR);
      acc   = ready & ~clear;
   end

   assign wr_en   = acc & we & ({1'b0, waddr} < ELEM_CNT);
   assign wr_word = DATA_WIDTH'(lane_merge(MAX_DW'(mem[waddr]), MAX_DW'(wdata),
                                           MAX_DW'(wbe), LANE_W));

   always_ff @(posedge clk) begin
      if (sweep)
         mem[clr_ptr] <= CLEAR_VAL;
      else if (wr_en)
         mem[waddr] <= wr_word;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      sram_rd_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .NUM_ELEM   (NUM_ELEM),
         .LANE_W     (LANE_W),
         .AW         (AW)
      ) u_port (
         .clk      (clk),
         .rst_n    (rst_n),
         .acc      (acc),
         .re       (re[i]),
         .raddr    (raddr[i]),
         .mem_word (mem[raddr[i]]),
         .wr_en    (wr_en),
         .waddr    (waddr),
         .wdata    (wdata),
         .wbe      (wbe),
         .rdata    (rdata[i]),
         .rvalid   (rvalid[i])
      );
   end

endmodule

// File: tb/tb_sram_bank_mp.sv
// Directed scoreboard bench: a 32-bit/8-word bank and an 8-bit/6-word bank side by side.
module tb_sram_bank_mp;

   localparam logic [31:0] CVA = 32'hDEADBEEF;
   localparam logic [7:0]  CVB = 8'h5A;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic             a_rst_n, a_clear, a_ready, a_we;
   logic [2:0]       a_waddr;
   logic [31:0]      a_wdata;
   logic [3:0]       a_wbe;
   logic [1:0]       a_re, a_rvalid;
   logic [1:0][2:0]  a_raddr;
   logic [1:0][31:0] a_rdata;

   logic             b_rst_n, b_clear, b_ready, b_we;
   logic [2:0]       b_waddr;
   logic [7:0]       b_wdata;
   logic [0:0]       b_wbe;
   logic [1:0]       b_re, b_rvalid;
   logic [1:0][2:0]  b_raddr;
   logic [1:0][7:0]  b_rdata;

   sram_bank_mp #(.DATA_WIDTH(32), .NUM_ELEM(8), .NUM_RD(2), .LANE_W(8), .CLEAR_VAL(CVA)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .clear(a_clear), .ready(a_ready), .we(a_we), .waddr(a_waddr),
      .wdata(a_wdata), .wbe(a_wbe), .re(a_re), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid));

   sram_bank_mp #(.DATA_WIDTH(8), .NUM_ELEM(6), .NUM_RD(2), .LANE_W(8), .CLEAR_VAL(CVB)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .clear(b_clear), .ready(b_ready), .we(b_we), .waddr(b_waddr),
      .wdata(b_wdata), .wbe(b_wbe), .re(b_re), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid));

   logic [31:0] qa[2][$];
   logic [31:0] qb[2][$];
   logic [31:0] ma[8];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_clear = 0; a_we = 0; a_re = 0; a_wbe = 0;
      b_clear = 0; b_we = 0; b_re = 0; b_wbe = 0;
   endtask

   // Drives a write on bank A and applies it to the model (lanes merged byte by byte).
   task automatic a_write(input logic [2:0] ad, input logic [31:0] d, input logic [3:0] be);
      a_we = 1; a_waddr = ad; a_wdata = d; a_wbe = be;
      for (int k = 0; k < 4; k++)
         if (be[k]) ma[ad][8*k +: 8] = d[8*k +: 8];
   endtask

   task automatic a_read(input int p, input logic [2:0] ad);
      a_re[p] = 1'b1; a_raddr[p] = ad;
      qa[p].push_back(ma[ad]);
   endtask

   task automatic b_read(input int p, input logic [2:0] ad, input logic [7:0] exp);
      b_re[p] = 1'b1; b_raddr[p] = ad;
      qb[p].push_back({24'h0, exp});
   endtask

   // Output monitor: every rvalid strobe must match the oldest expected word of its port.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (a_rvalid[i] === 1'b1) begin
            chk("a_rvalid_expected", 64'(qa[i].size() != 0), 64'd1);
            if (qa[i].size() != 0) chk("a_rdata", 64'(a_rdata[i]), 64'(qa[i].pop_front()));
         end
         if (b_rvalid[i] === 1'b1) begin
            chk("b_rvalid_expected", 64'(qb[i].size() != 0), 64'd1);
            if (qb[i].size() != 0) chk("b_rdata", 64'(b_rdata[i]), 64'(qb[i].pop_front()));
         end
      end
   end

   initial begin
      a_rst_n = 0; b_rst_n = 0;
      a_waddr = 0; a_wdata = 0; a_raddr = '0;
      b_waddr = 0; b_wdata = 0; b_raddr = '0;
      idle();
      for (int k = 0; k < 8; k++) ma[k] = CVA;
      tick(); tick();
      chk("rst_ready", {62'd0, a_ready, b_ready}, 64'd0);
      chk("rst_rvalid", {60'd0, a_rvalid, b_rvalid}, 64'd0);
      chk("rst_a_rdata", 64'(a_rdata), 64'd0);
      chk("rst_b_rdata", 64'(b_rdata), 64'd0);

      // Sweep timing after reset release
      a_rst_n = 1; b_rst_n = 1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("a_ready_sweep", 64'(a_ready), 64'(k >= 8));
         chk("b_ready_sweep", 64'(b_ready), 64'(k >= 6));
      end

      // Every word reads back the clear value
      for (int k = 0; k < 8; k++) begin
         idle();
         a_read(0, 3'(k));
         a_read(1, 3'(7 - k));
         if (k < 6) b_read(0, 3'(k), CVB);
         tick();
      end
      idle(); tick(); tick();

      // Two ports read the same freshly written word
      b_we = 1; b_waddr = 3; b_wdata = 8'hA5; b_wbe = 1'b1;
      tick(); idle();
      b_read(0, 3, 8'hA5); b_read(1, 3, 8'hA5);
      tick(); idle();
      chk("b_rvalid_both", 64'(b_rvalid), 64'd3);
      tick(); tick();

      // Partial-lane write with same-cycle read (write-first merge)
      a_write(5, 32'h11223344, 4'hF);
      tick(); idle();
      a_write(5, 32'hAABBCCDD, 4'b0101);
      a_read(0, 5);
      chk("a_merge_model", 64'(ma[5]), 64'h11BB33DD);
      tick(); idle();
      a_read(0, 5); a_read(1, 5);
      tick(); idle();
      a_we = 1; a_waddr = 6; a_wdata = 32'h01020304; a_wbe = 4'h0;
      tick(); idle();
      a_read(1, 6);
      tick(); idle(); tick(); tick();

      // Mid-stream clear drops the concurrent write and read
      a_write(2, 32'h0000007F, 4'hF);
      tick(); idle();
      a_clear = 1; a_we = 1; a_waddr = 4; a_wdata = 32'h12345678; a_wbe = 4'hF;
      a_re = 2'b01; a_raddr[0] = 2;
      tick(); idle();
      for (int k = 0; k < 8; k++) ma[k] = CVA;
      chk("a_ready_clear", 64'(a_ready), 64'd0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("a_ready_resweep", 64'(a_ready), 64'(k >= 8));
      end
      a_read(0, 2); a_read(1, 4);
      tick(); idle(); tick(); tick();

      // Out-of-range write ignored, out-of-range read returns zero
      b_we = 1; b_waddr = 7; b_wdata = 8'h55; b_wbe = 1'b1;
      tick(); idle();
      b_read(0, 7, 8'h00); b_read(1, 5, CVB);
      tick(); idle();
      chk("b_rvalid_oor", 64'(b_rvalid), 64'd3);
      b_read(0, 6, 8'h00); b_read(1, 3, 8'hA5);
      tick(); idle(); tick(); tick();

      // Continuous reads, then an asynchronous reset mid-stream
      a_write(1, 32'hCAFEF00D, 4'hF);
      tick(); idle();
      for (int k = 0; k < 10; k++) begin
         a_read(0, 3'(k % 8));
         a_read(1, 3'((k + 3) % 8));
         tick();
      end
      a_rst_n = 0;
      a_re = 2'b11;
      qa[0].delete(); qa[1].delete();
      #1;
      chk("a_rvalid_in_rst", 64'(a_rvalid), 64'd0);
      chk("a_ready_in_rst", 64'(a_ready), 64'd0);
      tick();
      chk("a_rvalid_in_rst2", 64'(a_rvalid), 64'd0);
      for (int k = 0; k < 8; k++) ma[k] = CVA;
      a_rst_n = 1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("a_ready_after_rst", 64'(a_ready), 64'(k >= 8));
         chk("a_rvalid_sweep", 64'(a_rvalid), 64'd0);
         if (k == 8) a_re = 2'b00;
      end
      a_read(0, 1); a_read(1, 7);
      tick(); idle(); tick(); tick();

      chk("drain_a0", 64'(qa[0].size()), 64'd0);
      chk("drain_a1", 64'(qa[1].size()), 64'd0);
      chk("drain_b0", 64'(qb[0].size()), 64'd0);
      chk("drain_b1", 64'(qb[1].size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
